// File: rtl/joydb_scan_ctrl.sv
// joydb_scan_ctrl
// ---------------------------------------------------------------------------
// Scans an external DB9 joystick chain built from 74HC165 shift registers.
// Each local frame does three things in order:
//    1. Pulses joy_load_n low to parallel-load the chain.
//    2. Clocks NBITS bits out of the chain with joy_clk.
//    3. Decodes the inverted bits into two 12-bit button words.
// A middleboard can request the chain (bypass_req). Once acknowledged, the
// chain clock/load/data are passed straight through to it until it releases.
//
// Parameters
//    CLKDIV   joy_clk half-period and load-pulse width in clk50mhz cycles (2..255)
//    NBITS    serial bits per frame, must stay 24 (2 x 12 buttons)
//
// Ports
//    clk50mhz     in   sole clock
//    reset_n      in   synchronous active-low reset
//    enable       in   permits local scanning
//    bypass_req   in   middleboard asks for the chain
//    bypass_ack   out  middleboard currently owns the chain
//    joy_data     in   serial data from the chain, buttons active-low
//    joy_clk      out  shift clock to the chain
//    joy_load_n   out  parallel-load strobe to the chain, active-low
//    joy_select   out  chain select, tied high
//    xjoy_clk     in   middleboard shift clock (used only in bypass)
//    xjoy_load_n  in   middleboard load strobe (used only in bypass)
//    xjoy_data    out  chain data returned to the middleboard, idles high
//    joy1, joy2   out  decoded buttons, active-high
//    frame_valid  out  one-cycle pulse at the end of each local frame
//
// Build option
//    JOYDB_DEBOUNCE_EN  when defined, joy1/joy2 only change after two
//                       identical consecutive frames.
// ---------------------------------------------------------------------------
module joydb_scan_ctrl #(
   parameter int CLKDIV = 8,
   parameter int NBITS  = 24
) (
   input  logic        clk50mhz,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        bypass_req,
   output logic        bypass_ack,
   input  logic        joy_data,
   output logic        joy_clk,
   output logic        joy_load_n,
   output logic        joy_select,
   input  logic        xjoy_clk,
   input  logic        xjoy_load_n,
   output logic        xjoy_data,
   output logic [11:0] joy1,
   output logic [11:0] joy2,
   output logic        frame_valid
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHLO,
      SHHI,
      DONE,
      BYP
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  phase_cnt;
   logic [4:0]  bit_cnt;
   logic [23:0] frame;
   logic        phase_end;
   logic        last_bit;
   logic        frame_end;

`ifdef JOYDB_DEBOUNCE_EN
   logic [23:0] prev_frame;
`endif

   assign phase_end = (phase_cnt == 8'(CLKDIV - 1));
   assign last_bit  = (bit_cnt == 5'(NBITS - 1));
   // Final cycle of the last SHHI phase: the whole frame is already captured.
   assign frame_end = (state == SHHI) && phase_end && last_bit;

   // The chain select has no other use on this board.
   assign joy_select = 1'b1;

   // State register.
   always_ff @(posedge clk50mhz) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Bypass is only granted between frames (IDLE or DONE),
   // so a frame that has started always runs to completion.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bypass_req) begin
               state_nxt = BYP;
            end else if (enable) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (phase_end) begin
               state_nxt = SHLO;
            end
         end
         SHLO: begin
            if (phase_end) begin
               state_nxt = SHHI;
            end
         end
         SHHI: begin
            if (phase_end) begin
               state_nxt = last_bit ? DONE : SHLO;
            end
         end
         DONE: begin
            if (bypass_req) begin
               state_nxt = BYP;
            end else if (enable) begin
               state_nxt = LOAD;
            end else begin
               state_nxt = IDLE;
            end
         end
         BYP: begin
            if (!bypass_req) begin
               state_nxt = enable ? LOAD : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode. In BYP the chain pins are wired straight to the
   // middleboard, so these paths are purely combinational.
   always_comb begin
      joy_clk     = 1'b0;
      joy_load_n  = 1'b1;
      xjoy_data   = 1'b1;
      bypass_ack  = 1'b0;
      frame_valid = 1'b0;
      case (state)
         LOAD: joy_load_n = 1'b0;
         SHHI: joy_clk = 1'b1;
         DONE: frame_valid = 1'b1;
         BYP: begin
            joy_clk    = xjoy_clk;
            joy_load_n = xjoy_load_n;
            xjoy_data  = joy_data;
            bypass_ack = 1'b1;
         end
         default: ;
      endcase
   end

   // Phase counter times each LOAD/SHLO/SHHI phase. The bit counter is
   // cleared during LOAD. It advances at the end of each SHHI phase,
   // except after the last bit.
   always_ff @(posedge clk50mhz) begin
      if (!reset_n) begin
         phase_cnt <= '0;
         bit_cnt   <= '0;
      end else begin
         case (state)
            LOAD, SHLO, SHHI: phase_cnt <= phase_end ? 8'd0 : phase_cnt + 8'd1;
            default:          phase_cnt <= '0;
         endcase
         if (state == LOAD) begin
            bit_cnt <= '0;
         end else if ((state == SHHI) && phase_end && !last_bit) begin
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

   // Frame capture and button outputs. Data is sampled at the very end of
   // the low half of joy_clk, just before the rising edge shifts the chain.
   // Buttons are active-low on the wire, so each bit is stored inverted.
   // joy1/joy2 are loaded on the edge into DONE, so they are already valid
   // while frame_valid is high.
   always_ff @(posedge clk50mhz) begin
      if (!reset_n) begin
         frame <= '0;
         joy1  <= '0;
         joy2  <= '0;
`ifdef JOYDB_DEBOUNCE_EN
         prev_frame <= '0;
`endif
      end else begin
         if ((state == SHLO) && phase_end) begin
            frame[bit_cnt] <= ~joy_data;
         end
         if (frame_end) begin
`ifdef JOYDB_DEBOUNCE_EN
            if (frame == prev_frame) begin
               joy1 <= frame[11:0];
               joy2 <= frame[23:12];
            end
            prev_frame <= frame;
`else
            joy1 <= frame[11:0];
            joy2 <= frame[23:12];
`endif
         end
      end
   end

endmodule

// File: tb/tb_joydb_scan_ctrl.sv
// tb_joydb_scan_ctrl
// Self-checking bench for joydb_scan_ctrl with default parameters.
// A behavioural 74HC165 chain model feeds joy_data from a button pattern.
// Each parallel load pushes the expected joy1/joy2 onto a scoreboard queue.
// Every frame_valid pulse pops that queue and compares the outputs.
module tb_joydb_scan_ctrl;

   logic        clk50mhz = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        bypass_req = 1'b0;
   logic        xjoy_clk = 1'b0;
   logic        xjoy_load_n = 1'b1;
   logic        joy_data;
   logic        bypass_ack;
   logic        joy_clk;
   logic        joy_load_n;
   logic        joy_select;
   logic        xjoy_data;
   logic [11:0] joy1;
   logic [11:0] joy2;
   logic        frame_valid;

   logic [11:0] pat_j1 = 12'h000;
   logic [11:0] pat_j2 = 12'h000;
   logic [23:0] chain = '1;
   logic        use_chain = 1'b1;
   logic        joy_data_drv = 1'b1;
   logic        prev_clk = 1'b0;
   logic        prev_load_n = 1'b1;
   int          load_cnt = 0;
   int          rise_cnt = 0;
   int          fv_count = 0;
   logic [23:0] m_out = '0;
`ifdef JOYDB_DEBOUNCE_EN
   logic [23:0] m_prev = '0;
`endif
   logic [23:0] sb_new;
   logic [23:0] sb_exp;
   logic [23:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;

   joydb_scan_ctrl dut (
      .clk50mhz    (clk50mhz),
      .reset_n     (reset_n),
      .enable      (enable),
      .bypass_req  (bypass_req),
      .bypass_ack  (bypass_ack),
      .joy_data    (joy_data),
      .joy_clk     (joy_clk),
      .joy_load_n  (joy_load_n),
      .joy_select  (joy_select),
      .xjoy_clk    (xjoy_clk),
      .xjoy_load_n (xjoy_load_n),
      .xjoy_data   (xjoy_data),
      .joy1        (joy1),
      .joy2        (joy2),
      .frame_valid (frame_valid)
   );

   always #10 clk50mhz = ~clk50mhz;

   assign joy_data = use_chain ? chain[0] : joy_data_drv;

   // Chain model: the chain loads continuously while load is low and shifts
   // right on each rising joy_clk. The first load cycle of a local frame
   // fixes the expected result and pushes it onto the scoreboard queue.
   always @(negedge clk50mhz) begin
      if (joy_load_n === 1'b0) begin
         if (prev_load_n && (bypass_ack === 1'b0)) begin
            load_cnt = 0;
            rise_cnt = 0;
            sb_new   = {pat_j2, pat_j1};
`ifdef JOYDB_DEBOUNCE_EN
            if (sb_new == m_prev) m_out = sb_new;
            m_prev = sb_new;
`else
            m_out = sb_new;
`endif
            exp_q.push_back(m_out);
         end
         chain = ~{pat_j2, pat_j1};
         load_cnt++;
      end else if ((joy_clk === 1'b1) && !prev_clk) begin
         chain = {1'b1, chain[23:1]};
         rise_cnt++;
      end
      prev_clk    = (joy_clk === 1'b1);
      prev_load_n = (joy_load_n !== 1'b0);
   end

   // Scoreboard: every frame_valid pulse must match a pending frame.
   always @(negedge clk50mhz) begin
      if (frame_valid === 1'b1) begin
         fv_count++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL sb_unexpected_frame: frame_valid with no pending frame, joy2/joy1=%h/%h",
                     joy2, joy1);
         end else begin
            sb_exp = exp_q.pop_front();
            if ({joy2, joy1} !== sb_exp) begin
               n_fail++;
               $display("[TB] FAIL sb_frame: joy2/joy1 got %h/%h want %h/%h",
                        joy2, joy1, sb_exp[23:12], sb_exp[11:0]);
            end
         end
      end
   end

   // Clears the reference model, as the DUT does on reset.
   task automatic reset_model();
      exp_q.delete();
      m_out = '0;
`ifdef JOYDB_DEBOUNCE_EN
      m_prev = '0;
`endif
   endtask

   // Waits for the next frame_valid pulse. Returns negedges waited, or -1 on timeout.
   task automatic wait_frame_valid(input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk50mhz);
         cycles++;
      end while ((frame_valid !== 1'b1) && (cycles < budget));
      if (frame_valid !== 1'b1) cycles = -1;
   endtask

   task automatic test_reset();
      logic [5:0] obs;
      reset_n = 1'b0;
      enable = 1'b0;
      bypass_req = 1'b0;
      reset_model();
      repeat (3) @(negedge clk50mhz);
      obs = {joy_select, joy_clk, joy_load_n, xjoy_data, bypass_ack, frame_valid};
      n_checks++;
      if (obs !== 6'b101100) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: sel/clk/load_n/xdata/ack/fv got %b want 101100", obs);
      end
      n_checks++;
      if ({joy2, joy1} !== 24'h000000) begin
         n_fail++;
         $display("[TB] FAIL reset_joy: got %h want 000000", {joy2, joy1});
      end
      reset_n = 1'b1;
      repeat (5) @(negedge clk50mhz);
      n_checks++;
      if ((joy_load_n !== 1'b1) || (frame_valid !== 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL idle_no_enable: load_n=%b fv=%b want 1/0", joy_load_n, frame_valid);
      end
   endtask

   task automatic test_frame_timing();
      int cyc;
      int wcyc;
      pat_j1 = 12'hFFF;
      pat_j2 = 12'hFFF;
      enable = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk50mhz);
         cyc++;
      end while ((joy_load_n !== 1'b0) && (cyc < 20));
      n_checks++;
      if (joy_load_n !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL load_start: joy_load_n got %b want 0 within 20 cycles", joy_load_n);
      end
      wait_frame_valid(1000, wcyc);
      n_checks++;
      if (wcyc + 1 != 393) begin
         n_fail++;
         $display("[TB] FAIL first_frame_latency: got %0d want 393", wcyc + 1);
      end
      n_checks++;
      if (load_cnt != 8) begin
         n_fail++;
         $display("[TB] FAIL load_width: got %0d want 8", load_cnt);
      end
      n_checks++;
      if (rise_cnt != 24) begin
         n_fail++;
         $display("[TB] FAIL clk_rises: got %0d want 24", rise_cnt);
      end
      wait_frame_valid(1000, wcyc);
      n_checks++;
      if (wcyc != 393) begin
         n_fail++;
         $display("[TB] FAIL frame_period: got %0d want 393", wcyc);
      end
      n_checks++;
      if ({joy2, joy1} !== 24'hFFFFFF) begin
         n_fail++;
         $display("[TB] FAIL all_pressed: got %h want FFFFFF", {joy2, joy1});
      end
   endtask

   task automatic test_pattern();
      int wcyc;
      pat_j1 = 12'h501;
      pat_j2 = 12'h00A;
      wait_frame_valid(1000, wcyc);
      wait_frame_valid(1000, wcyc);
      n_checks++;
      if ((joy1 !== 12'h501) || (joy2 !== 12'h00A)) begin
         n_fail++;
         $display("[TB] FAIL pattern: joy1/joy2 got %h/%h want 501/00A", joy1, joy2);
      end
      n_checks++;
      if ((load_cnt != 8) || (rise_cnt != 24)) begin
         n_fail++;
         $display("[TB] FAIL pattern_shape: load=%0d rises=%0d want 8/24", load_cnt, rise_cnt);
      end
   endtask

   task automatic test_bypass();
      int cyc;
      int wcyc;
      logic [4:0] exp5;
      logic [4:0] obs5;
      cyc = 0;
      do begin
         @(negedge clk50mhz);
         #1;
         cyc++;
      end while ((rise_cnt != 10) && (cyc < 1000));
      bypass_req = 1'b1;
      wait_frame_valid(1000, wcyc);
      n_checks++;
      if ((wcyc < 0) || (bypass_ack !== 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL bypass_frame_completes: wait=%0d ack=%b want >0/0", wcyc, bypass_ack);
      end
      @(negedge clk50mhz);
      n_checks++;
      if ((bypass_ack !== 1'b1) || (frame_valid !== 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL bypass_ack: ack/fv got %b/%b want 1/0", bypass_ack, frame_valid);
      end
      use_chain = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk50mhz);
         xjoy_clk = i[0];
         xjoy_load_n = i[1];
         joy_data_drv = ~i[0];
         #1;
         exp5 = {i[0], i[1], ~i[0], 2'b10};
         obs5 = {joy_clk, joy_load_n, xjoy_data, bypass_ack, frame_valid};
         n_checks++;
         if (obs5 !== exp5) begin
            n_fail++;
            $display("[TB] FAIL bypass_passthru: clk/load_n/xdata/ack/fv got %b want %b", obs5, exp5);
         end
      end
      n_checks++;
      if ((joy1 !== 12'h501) || (joy2 !== 12'h00A)) begin
         n_fail++;
         $display("[TB] FAIL bypass_hold: joy1/joy2 got %h/%h want 501/00A", joy1, joy2);
      end
   endtask

   task automatic test_bypass_exit();
      int wcyc;
      @(negedge clk50mhz);
      xjoy_clk = 1'b0;
      xjoy_load_n = 1'b1;
      use_chain = 1'b1;
      @(negedge clk50mhz);
      bypass_req = 1'b0;
      @(negedge clk50mhz);
      n_checks++;
      if ({bypass_ack, joy_load_n, xjoy_data} !== 3'b001) begin
         n_fail++;
         $display("[TB] FAIL bypass_exit: ack/load_n/xdata got %b want 001",
                  {bypass_ack, joy_load_n, xjoy_data});
      end
      wait_frame_valid(1000, wcyc);
      n_checks++;
      if (wcyc + 1 != 393) begin
         n_fail++;
         $display("[TB] FAIL bypass_exit_latency: got %0d want 393", wcyc + 1);
      end
   endtask

   task automatic test_enable_drop();
      int wcyc;
      int lows;
      repeat (100) @(negedge clk50mhz);
      enable = 1'b0;
      wait_frame_valid(1000, wcyc);
      n_checks++;
      if (wcyc < 0) begin
         n_fail++;
         $display("[TB] FAIL enable_drop_complete: frame_valid got timeout want pulse");
      end
      lows = 0;
      repeat (20) begin
         @(negedge clk50mhz);
         if ((joy_load_n !== 1'b1) || (frame_valid !== 1'b0)) lows++;
      end
      n_checks++;
      if (lows != 0) begin
         n_fail++;
         $display("[TB] FAIL enable_drop_idle: active cycles got %0d want 0", lows);
      end
   endtask

   task automatic test_debounce();
      int wcyc;
      int fv0;
      logic [11:0] exp_j1;
      fv0 = fv_count;
      pat_j1 = 12'h123;
      pat_j2 = 12'h00A;
      enable = 1'b1;
      wait_frame_valid(1000, wcyc);
      pat_j1 = 12'h456;
      wait_frame_valid(1000, wcyc);
`ifdef JOYDB_DEBOUNCE_EN
      exp_j1 = 12'h501;
`else
      exp_j1 = 12'h456;
`endif
      n_checks++;
      if (joy1 !== exp_j1) begin
         n_fail++;
         $display("[TB] FAIL debounce_second: joy1 got %h want %h", joy1, exp_j1);
      end
      wait_frame_valid(1000, wcyc);
      enable = 1'b0;
      n_checks++;
      if (joy1 !== 12'h456) begin
         n_fail++;
         $display("[TB] FAIL debounce_third: joy1 got %h want 456", joy1);
      end
      #1;
      n_checks++;
      if (fv_count - fv0 != 3) begin
         n_fail++;
         $display("[TB] FAIL debounce_pulses: got %0d want 3", fv_count - fv0);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int fv0;
      logic [4:0] obs;
      enable = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk50mhz);
         cyc++;
      end while ((joy_clk !== 1'b1) && (cyc < 100));
      reset_n = 1'b0;
      enable = 1'b0;
      @(negedge clk50mhz);
      reset_n = 1'b1;
      reset_model();
      obs = {joy_clk, joy_load_n, bypass_ack, frame_valid, xjoy_data};
      n_checks++;
      if (obs !== 5'b01001) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_outputs: clk/load_n/ack/fv/xdata got %b want 01001", obs);
      end
      n_checks++;
      if ({joy2, joy1} !== 24'h000000) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_joy: got %h want 000000", {joy2, joy1});
      end
      #1;
      fv0 = fv_count;
      repeat (500) @(negedge clk50mhz);
      #1;
      n_checks++;
      if (fv_count != fv0) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_no_frame: pulses got %0d want 0", fv_count - fv0);
      end
   endtask

   initial begin
      $display("[TB] joydb_scan_ctrl bench start");
      test_reset();
      test_frame_timing();
      test_pattern();
      test_bypass();
      test_bypass_exit();
      test_enable_drop();
      test_debounce();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/joydb_scan_ctrl.md
JOYDB_SCAN_CTRL -- requirements
Module: joydb_scan_ctrl

Interface
REQ-001 Parameter CLKDIV, default 8: joy_clk half-period and load-pulse width, in clk50mhz cycles, legal range 2..255.
REQ-002 Parameter NBITS, default 24: serial bits per frame, fixed at 2 x 12; this block does not support other values.
REQ-003 clk50mhz  in  1  sole clock.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 enable  in  1  permits local scanning.
REQ-006 bypass_req  in  1  middleboard requests ownership of the DB9 chain.
REQ-007 bypass_ack  out  1  middleboard owns the chain.
REQ-008 joy_data  in  1  serial data from the external 74HC165 chain, buttons active-low.
REQ-009 joy_clk  out  1  shift clock to the chain.
REQ-010 joy_load_n  out  1  parallel-load strobe to the chain, active-low.
REQ-011 joy_select  out  1  chain select, constant 1.
REQ-012 xjoy_clk, xjoy_load_n  in  1 each  middleboard-driven clock and load.
REQ-013 xjoy_data  out  1  data returned to the middleboard.
REQ-014 joy1, joy2  out  12 each  decoded buttons, active-high.
REQ-015 frame_valid  out  1  one-cycle pulse marking the end of each local frame.

Function
REQ-016 FSM states: IDLE, LOAD, SHLO, SHHI, DONE, BYP. A phase counter counts 0..CLKDIV-1, and a bit counter counts 0..NBITS-1.
REQ-017 IDLE: go to BYP if bypass_req=1; otherwise go to LOAD if enable=1; otherwise stay in IDLE.
REQ-018 LOAD: joy_load_n=0 and joy_clk=0 for CLKDIV cycles, then go to SHLO with bit counter=0.
REQ-019 SHLO: joy_load_n=1 and joy_clk=0 for CLKDIV cycles; joy_data is sampled on the last cycle of this phase, then go to SHHI.
REQ-020 SHHI: joy_clk=1 for CLKDIV cycles. After that, go to SHLO if the bit counter is less than NBITS-1 (incrementing the counter); otherwise go to DONE.
REQ-021 Bit storage: the bit sampled at bit counter i is stored inverted into frame[i]; joy1=frame[11:0] and joy2=frame[23:12].
REQ-022 DONE lasts 1 cycle: outputs are updated (see REQ-031) and frame_valid=1. The next state is BYP if bypass_req=1, LOAD if enable=1, or IDLE otherwise.
REQ-023 Frame period with the defaults is CLKDIV*(1+2*NBITS)+1 = 393 cycles, back-to-back.
REQ-024 bypass_req is honoured only in IDLE or DONE; an in-progress frame always completes, and there is no mid-frame takeover.
REQ-025 BYP: bypass_ack=1, joy_clk=xjoy_clk, joy_load_n=xjoy_load_n, xjoy_data=joy_data (combinational passthrough); joy1/joy2 hold their values and frame_valid stays 0.
REQ-026 BYP exit: when bypass_req=0, bypass_ack falls on the next cycle and the FSM enters LOAD if enable=1, or IDLE otherwise.
REQ-027 Outside BYP, xjoy_data=1 and the xjoy_* inputs are ignored.
REQ-028 If enable falls mid-frame, the frame completes and the FSM then goes to IDLE.
REQ-029 joy_select=1 at all times, including during reset.

Reset
REQ-030 While reset_n=0 at a clk50mhz edge: the FSM enters IDLE and all counters clear. Outputs take these values: joy_clk=0, joy_load_n=1, xjoy_data=1, bypass_ack=0, frame_valid=0, joy1=0, joy2=0, and frame=0. A reset asserted mid-frame or in BYP aborts immediately.

Configuration
REQ-031 Macro JOYDB_DEBOUNCE_EN.
- Defined: a previous-frame register (24 bits, reset 0) is kept. On DONE, joy1/joy2 update only if the new frame equals the previous frame. The previous-frame register is always overwritten, and frame_valid still pulses every frame.
- Undefined: joy1/joy2 update on every DONE, and no previous-frame register exists.

Verification
REQ-032 Reset, then enable=1 with joy_data held at 0 → first frame_valid at cycle 393 after LOAD entry; joy1=0xFFF, joy2=0xFFF (one frame without debounce, two with JOYDB_DEBOUNCE_EN).
REQ-033 Chain model returns frame bits 0..23 = ~{joy2=0x00A, joy1=0x501} → joy1=0x501, joy2=0x00A; joy_load_n low for exactly 8 cycles; 24 joy_clk rising edges per frame.
REQ-034 Assert bypass_req at bit 10 of a frame → frame completes and frame_valid pulses, then bypass_ack=1 on the next cycle; toggling xjoy_clk/xjoy_load_n appears on joy_clk/joy_load_n; xjoy_data follows joy_data.
REQ-035 Deassert bypass_req with enable=1 → bypass_ack=0 on the next cycle, LOAD is entered, xjoy_data=1, and a new frame completes 393 cycles later.
REQ-036 Debounce (macro defined): frames 0x123 / 0x456 / 0x456 for joy1 → joy1 stays at its old value after the second frame and becomes 0x456 after the third; frame_valid pulses all three times.
REQ-037 reset_n=0 for 1 cycle during SHHI → the next cycle shows joy_clk=0, joy_load_n=1, joy1=joy2=0, and the FSM in IDLE; the bench checks that no frame_valid pulse occurs.
